// File: rtl/alu_arbiter_if.sv
// One requester channel of the ALU arbiter: request handshake with operands,
// and response handshake carrying result/zero/branch back to the requester.
interface alu_arbiter_if #(
  parameter int WIDTH = 32,
  parameter int OPW   = 3
);
  logic             req_valid;
  logic             req_ready;
  logic [WIDTH-1:0] req_data1;
  logic [WIDTH-1:0] req_data2;
  logic [OPW-1:0]   req_aluop;
  logic             resp_valid;
  logic             resp_ready;
  logic [WIDTH-1:0] resp_result;
  logic             resp_zero;
  logic             resp_branch;

  modport master (
    output req_valid, req_data1, req_data2, req_aluop, resp_ready,
    input  req_ready, resp_valid, resp_result, resp_zero, resp_branch
  );

  modport slave (
    input  req_valid, req_data1, req_data2, req_aluop, resp_ready,
    output req_ready, resp_valid, resp_result, resp_zero, resp_branch
  );
endinterface

// File: rtl/alu_arbiter.sv
// Round-robin sharing of one combinational ALU between two requesters:
// accept -> one EXEC cycle driving the ALU -> hold response until consumed.
module alu_arbiter #(
  parameter int WIDTH = 32,
  parameter int OPW   = 3
) (
  input  logic             clk,
  input  logic             rst_n,
  alu_arbiter_if.slave     port0,
  alu_arbiter_if.slave     port1,
  output logic [WIDTH-1:0] alu_data1,
  output logic [WIDTH-1:0] alu_data2,
  output logic [OPW-1:0]   alu_op,
  input  logic [WIDTH-1:0] alu_result,
  input  logic             alu_zero,
  input  logic             alu_branch
);

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    EXEC = 2'd1,
    RESP = 2'd2
  } state_t;

  state_t           state;
  logic             ptr;
  logic             owner;
  logic             grant0;
  logic             grant1;
  logic             resp0_valid;
  logic             resp1_valid;
  logic [WIDTH-1:0] resp0_result;
  logic [WIDTH-1:0] resp1_result;
  logic             resp0_zero;
  logic             resp1_zero;
  logic             resp0_branch;
  logic             resp1_branch;
  logic [WIDTH-1:0] san_result;
  logic             san_zero;
  logic             san_branch;

  // Arbitration: only in IDLE; the pointer breaks ties when both ports ask
  always_comb begin
    grant0 = 1'b0;
    grant1 = 1'b0;
    if (state == IDLE) begin
      if (port0.req_valid && port1.req_valid) begin
        grant0 = ~ptr;
        grant1 = ptr;
      end else begin
        grant0 = port0.req_valid;
        grant1 = port1.req_valid;
      end
    end else begin
      grant0 = 1'b0;
      grant1 = 1'b0;
    end
  end

  // The ALU leaves stale flags on ops that do not produce them; mask those off
  always_comb begin
    san_result = '0;
    san_zero   = 1'b0;
    san_branch = 1'b0;
    case (alu_op)
      3'b010, 3'b110, 3'b000, 3'b001, 3'b111: begin
        san_result = alu_result;
        san_zero   = alu_zero;
      end
      3'b011, 3'b101: begin
        san_branch = alu_branch;
      end
      default: begin
        san_result = '0;
        san_zero   = 1'b0;
        san_branch = 1'b0;
      end
    endcase
  end

  // Control FSM with latched operands and per-port response registers
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state        <= IDLE;
      ptr          <= 1'b0;
      owner        <= 1'b0;
      alu_data1    <= '0;
      alu_data2    <= '0;
      alu_op       <= 3'b010;
      resp0_valid  <= 1'b0;
      resp1_valid  <= 1'b0;
      resp0_result <= '0;
      resp1_result <= '0;
      resp0_zero   <= 1'b0;
      resp1_zero   <= 1'b0;
      resp0_branch <= 1'b0;
      resp1_branch <= 1'b0;
    end else begin
      case (state)
        IDLE: begin
          if (grant0) begin
            alu_data1 <= port0.req_data1;
            alu_data2 <= port0.req_data2;
            alu_op    <= port0.req_aluop;
            owner     <= 1'b0;
            state     <= EXEC;
          end else if (grant1) begin
            alu_data1 <= port1.req_data1;
            alu_data2 <= port1.req_data2;
            alu_op    <= port1.req_aluop;
            owner     <= 1'b1;
            state     <= EXEC;
          end
        end
        EXEC: begin
          if (owner == 1'b0) begin
            resp0_result <= san_result;
            resp0_zero   <= san_zero;
            resp0_branch <= san_branch;
            resp0_valid  <= 1'b1;
          end else begin
            resp1_result <= san_result;
            resp1_zero   <= san_zero;
            resp1_branch <= san_branch;
            resp1_valid  <= 1'b1;
          end
          state <= RESP;
        end
        RESP: begin
          if ((owner == 1'b0) && port0.resp_ready) begin
            resp0_valid <= 1'b0;
            ptr         <= 1'b1;
            state       <= IDLE;
          end else if ((owner == 1'b1) && port1.resp_ready) begin
            resp1_valid <= 1'b0;
            ptr         <= 1'b0;
            state       <= IDLE;
          end
        end
        default: begin
          state <= IDLE;
        end
      endcase
    end
  end

  assign port0.req_ready   = grant0;
  assign port1.req_ready   = grant1;
  assign port0.resp_valid  = resp0_valid;
  assign port1.resp_valid  = resp1_valid;
  assign port0.resp_result = resp0_result;
  assign port1.resp_result = resp1_result;
  assign port0.resp_zero   = resp0_zero;
  assign port1.resp_zero   = resp1_zero;
  assign port0.resp_branch = resp0_branch;
  assign port1.resp_branch = resp1_branch;

endmodule

// File: tb/tb_alu_arbiter.sv
// Scoreboard bench for alu_arbiter: directed requests push expected responses,
// a negedge monitor compares every presented response against the queue head.
module tb_alu_arbiter;

  logic        clk = 1'b0;
  logic        rst_n = 1'b0;
  logic [31:0] alu_data1;
  logic [31:0] alu_data2;
  logic [2:0]  alu_op;
  logic [31:0] alu_result;
  logic        alu_zero;
  logic        alu_branch;

  alu_arbiter_if #(.WIDTH(32), .OPW(3)) if0 ();
  alu_arbiter_if #(.WIDTH(32), .OPW(3)) if1 ();

  alu_arbiter #(.WIDTH(32), .OPW(3)) dut (
    .clk        (clk),
    .rst_n      (rst_n),
    .port0      (if0),
    .port1      (if1),
    .alu_data1  (alu_data1),
    .alu_data2  (alu_data2),
    .alu_op     (alu_op),
    .alu_result (alu_result),
    .alu_zero   (alu_zero),
    .alu_branch (alu_branch)
  );

  always #5 clk = ~clk;

  int cyc = 0;
  always @(posedge clk) cyc <= cyc + 1;

  // ALU model; outputs that a real ALU would leave stale get junk values
  always_comb begin
    alu_result = 32'h0;
    alu_zero   = 1'b0;
    alu_branch = 1'b1;
    case (alu_op)
      3'b010: alu_result = alu_data1 + alu_data2;
      3'b110: alu_result = alu_data1 - alu_data2;
      3'b000: alu_result = alu_data1 & alu_data2;
      3'b001: alu_result = alu_data1 | alu_data2;
      3'b111: alu_result = ($signed(alu_data1) < $signed(alu_data2)) ? 32'd1 : 32'd0;
      3'b011: alu_result = 32'hDEAD_BEEF;
      3'b101: alu_result = 32'hDEAD_BEEF;
      default: alu_result = alu_data1 | alu_data2 | 32'd1;
    endcase
    case (alu_op)
      3'b011: begin alu_branch = (alu_data1 != alu_data2); alu_zero = 1'b1; end
      3'b101: begin alu_branch = (alu_data1 == alu_data2); alu_zero = 1'b1; end
      3'b100: alu_zero = 1'b0;
      default: alu_zero = (alu_result == 32'h0);
    endcase
  end

  typedef struct {
    int          port;
    logic [31:0] result;
    logic        zero;
    logic        branch;
    int          vcyc;
  } exp_t;

  exp_t sbq[$];
  int   acc_port[$];
  int   acc_cyc[$];
  int   n_cmp = 0;
  int   n_err = 0;

  task automatic chk(input string nm, input longint act, input longint req);
    n_cmp++;
    if (act != req) begin
      n_err++;
      $display("FAIL %s: got 0x%0h, expected 0x%0h (cycle %0d)", nm, act, req, cyc);
    end
  endtask

  task automatic drive(input int p, input logic v, input logic [31:0] d1, input logic [31:0] d2,
                       input logic [2:0] op);
    if (p == 0) begin
      if0.req_valid = v; if0.req_data1 = d1; if0.req_data2 = d2; if0.req_aluop = op;
    end else begin
      if1.req_valid = v; if1.req_data1 = d1; if1.req_data2 = d2; if1.req_aluop = op;
    end
  endtask

  // Called just after a rising edge; returns just after the edge that accepted it
  task automatic issue(input int p, input logic [31:0] d1, input logic [31:0] d2,
                       input logic [2:0] op, input logic [31:0] er, input logic ez, input logic eb);
    exp_t e;
    bit   got;
    got = 1'b0;
    drive(p, 1'b1, d1, d2, op);
    for (int n = 0; n < 60 && !got; n++) begin
      @(negedge clk);
      if ((p == 0) ? if0.req_ready : if1.req_ready) begin
        got = 1'b1;
        e.port = p; e.result = er; e.zero = ez; e.branch = eb; e.vcyc = cyc + 2;
        sbq.push_back(e);
        acc_port.push_back(p);
        acc_cyc.push_back(cyc);
      end
    end
    @(posedge clk); #1;
    drive(p, 1'b0, ~d1, ~d2, ~op);
    if (!got) begin
      n_cmp++; n_err++;
      $display("FAIL accept_timeout: port %0d got no ready, expected a grant", p);
    end
  endtask

  bit pv0 = 1'b0;
  bit pv1 = 1'b0;
  int mp;
  bit mready;
  bit mprev;
  exp_t me;

  // Monitor: every presented response must match the queue head
  always @(negedge clk) begin
    if (!rst_n) begin
      pv0 = 1'b0;
      pv1 = 1'b0;
    end else begin
      if (if0.resp_valid && if1.resp_valid) chk("both_resp_valid", 1, 0);
      if (if0.resp_valid || if1.resp_valid) begin
        mp     = if0.resp_valid ? 0 : 1;
        mready = (mp == 0) ? if0.resp_ready : if1.resp_ready;
        mprev  = (mp == 0) ? pv0 : pv1;
        if (sbq.size() == 0) begin
          chk("unexpected_resp_port", mp, -1);
        end else begin
          me = sbq[0];
          chk("resp_port", mp, me.port);
          chk("resp_result", (mp == 0) ? if0.resp_result : if1.resp_result, me.result);
          chk("resp_zero", (mp == 0) ? if0.resp_zero : if1.resp_zero, me.zero);
          chk("resp_branch", (mp == 0) ? if0.resp_branch : if1.resp_branch, me.branch);
          if (!mprev) chk("resp_latency_cycle", cyc, me.vcyc);
          if (mready) void'(sbq.pop_front());
        end
      end
      pv0 = if0.resp_valid;
      pv1 = if1.resp_valid;
    end
  end

  initial begin
    #200000;
    $display("FAIL watchdog: simulation time exceeded, expected completion");
    $fatal(1, "watchdog");
  end

  initial begin
    int seen;
    int base;
    bit got;
    drive(0, 1'b0, 32'd0, 32'd0, 3'b000);
    drive(1, 1'b0, 32'd0, 32'd0, 3'b000);
    if0.resp_ready = 1'b1;
    if1.resp_ready = 1'b1;
    repeat (3) @(posedge clk);
    #1;
    chk("reset_resp0_valid", if0.resp_valid, 0);
    chk("reset_resp1_valid", if1.resp_valid, 0);
    chk("reset_alu_op", alu_op, 3'b010);
    chk("reset_alu_data1", alu_data1, 0);
    rst_n = 1'b1;
    @(posedge clk); #1;

    // Single ADD; afterwards the pointer favours port 1
    issue(0, 32'd5, 32'd7, 3'b010, 32'd12, 1'b0, 1'b0);
    repeat (3) @(posedge clk);
    #1;

    // Reset in the middle of EXEC for a port-0 operation
    drive(0, 1'b1, 32'd20, 32'd22, 3'b010);
    got = 1'b0;
    for (int n = 0; n < 20 && !got; n++) begin
      @(negedge clk);
      if (if0.req_ready) got = 1'b1;
    end
    chk("rst_test_accept", got, 1);
    @(posedge clk); #1;
    drive(0, 1'b0, 32'd0, 32'd0, 3'b000);
    rst_n = 1'b0;
    #1;
    chk("midexec_rst_resp0_valid", if0.resp_valid, 0);
    chk("midexec_rst_resp0_result", if0.resp_result, 0);
    chk("midexec_rst_alu_op", alu_op, 3'b010);
    chk("midexec_rst_alu_data1", alu_data1, 0);
    chk("midexec_rst_alu_data2", alu_data2, 0);
    @(posedge clk); @(posedge clk); #1;
    rst_n = 1'b1;
    seen = 0;
    repeat (6) begin
      @(negedge clk);
      if (if0.resp_valid) seen++;
    end
    chk("no_resp_after_reset", seen, 0);
    @(posedge clk); #1;

    // Round-robin with both ports continuously requesting
    base = acc_port.size();
    fork
      begin
        issue(0, 32'd1, 32'd2, 3'b010, 32'd3, 1'b0, 1'b0);
        issue(0, 32'd8, 32'd1, 3'b001, 32'd9, 1'b0, 1'b0);
      end
      begin
        issue(1, 32'd10, 32'd3, 3'b110, 32'd7, 1'b0, 1'b0);
        issue(1, 32'd2, 32'd5, 3'b111, 32'd1, 1'b0, 1'b0);
      end
    join
    if (acc_port.size() == base + 4) begin
      for (int i = 0; i < 4; i++) chk("rr_grant_order", acc_port[base+i], i % 2);
      for (int i = 1; i < 4; i++) chk("rr_accept_spacing", acc_cyc[base+i] - acc_cyc[base+i-1], 3);
    end else begin
      chk("rr_accept_count", acc_port.size() - base, 4);
    end
    repeat (3) @(posedge clk);
    #1;

    // Back-pressure on port 1 while port 0 keeps requesting
    if1.resp_ready = 1'b0;
    fork
      issue(1, 32'd9, 32'd9, 3'b110, 32'd0, 1'b1, 1'b0);
      begin
        got = 1'b0;
        for (int n = 0; n < 20 && !got; n++) begin
          @(negedge clk);
          if (if1.req_ready) got = 1'b1;
        end
        @(posedge clk); #1;
        drive(0, 1'b1, 32'd100, 32'd1, 3'b010);
        got = 1'b0;
        for (int n = 0; n < 20 && !got; n++) begin
          @(negedge clk);
          chk("bp_req0_ready_low", if0.req_ready, 0);
          if (if1.resp_valid) got = 1'b1;
        end
        chk("bp_resp1_seen", got, 1);
        for (int k = 0; k < 4; k++) begin
          if (k > 0) @(negedge clk);
          chk("bp_resp1_held", if1.resp_valid, 1);
          chk("bp_req0_ready_low", if0.req_ready, 0);
        end
        @(posedge clk); #1;
        if1.resp_ready = 1'b1;
        @(negedge clk);
        chk("bp_req0_ready_low", if0.req_ready, 0);
        @(posedge clk); #1;
        drive(0, 1'b0, 32'd0, 32'd0, 3'b000);
      end
    join
    repeat (3) @(posedge clk);
    #1;

    // Branch sanitising and a following logic op
    issue(0, 32'd3, 32'd3, 3'b101, 32'd0, 1'b0, 1'b1);
    issue(0, 32'd6, 32'd3, 3'b000, 32'd2, 1'b0, 1'b0);
    issue(0, 32'd4, 32'd4, 3'b011, 32'd0, 1'b0, 1'b0);
    issue(0, 32'd4, 32'd5, 3'b011, 32'd0, 1'b0, 1'b1);
    // Undefined opcode completes with everything cleared
    issue(1, 32'h30, 32'h0C, 3'b100, 32'd0, 1'b0, 1'b0);

    for (int n = 0; n < 100 && sbq.size() != 0; n++) @(posedge clk);
    @(negedge clk);
    chk("scoreboard_drained", sbq.size(), 0);
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
    $finish;
  end

endmodule

// File: doc/alu_arbiter.md
Name: alu_arbiter

Overview:
- Shares one ALU instance between two requesters (port 0, port 1), with round-robin arbitration.
- Accepts an operation on a valid/ready handshake and latches its operands.
- Drives the ALU with the latched operands for one cycle, captures result/zero/branch, and returns them to the winning requester on a valid/ready response handshake.
- Sits between the control/decode logic and the ALU. The ALU stays combinational; this block is its only driver.

Parameters:
- WIDTH, 32, operand and result width.
- OPW, 3, ALU operation code width.

Ports:
- clk  in  1  single clock, rising edge.
- rst_n  in  1  asynchronous, active-low reset.
- req0_valid  in  1  port 0 request valid.
- req0_ready  out  1  port 0 request accepted this cycle.
- req0_data1  in  WIDTH  port 0 operand 1.
- req0_data2  in  WIDTH  port 0 operand 2.
- req0_aluop  in  OPW  port 0 ALU operation.
- resp0_valid  out  1  port 0 response valid.
- resp0_ready  in  1  port 0 response consumed.
- resp0_result  out  WIDTH  port 0 result.
- resp0_zero  out  1  port 0 zero flag.
- resp0_branch  out  1  port 0 branch flag.
- req1_*/resp1_*: identical set for port 1.
- alu_data1  out  WIDTH  ALU operand 1.
- alu_data2  out  WIDTH  ALU operand 2.
- alu_op  out  OPW  ALU operation.
- alu_result  in  WIDTH  ALU result.
- alu_zero  in  1  ALU zero flag.
- alu_branch  in  1  ALU branch flag.

Behaviour:
- Reset (rst_n low, asynchronous):
  - state=IDLE, priority pointer=port 0.
  - Operand registers=0, alu_op=3'b010 (ADD).
  - All resp*_valid=0, resp*_result=0, zero=0, branch=0.
  - Any in-flight transaction is dropped; no response is produced after reset is released.
- FSM states: IDLE, EXEC, RESP.
- IDLE:
  - reqN_ready is combinational and asserted only for the arbitration winner; the other port's ready=0.
  - Winner: the only valid port, or the pointer port if both are valid.
  - On handshake (valid & ready): latch data1/data2/aluop and owner id -> EXEC.
  - No valid request: stay IDLE.
- EXEC (exactly 1 cycle):
  - alu_data1/alu_data2/alu_op come from the latched registers. They are stable from the cycle after acceptance until the next acceptance.
  - Register the ALU outputs into the owner's response registers at the clock edge -> RESP.
- RESP:
  - The owner's respN_valid=1; the other port's resp_valid=0.
  - Response data is held stable while valid & !ready.
  - On respN_ready: respN_valid drops next cycle, pointer = other port -> IDLE.
  - No request is accepted while in EXEC or RESP; all req*_ready=0.
- Latency: acceptance at cycle T -> resp_valid asserted at T+2 (when resp_ready is already high, also consumed at T+2). Maximum throughput is 1 operation per 3 cycles.
- Response sanitising (the ALU updates branch only on branch ops and result only on non-branch ops):
  - Ops 010/110/000/001/111: result=alu_result, zero=alu_zero, branch=0.
  - Ops 011 (BNE) / 101 (BEQ): result=0, zero=0, branch=alu_branch.
  - Op 100 (undefined): accepted and completed with result=0, zero=0, branch=0.
- Requester inputs changing while not ready: ignored; only handshake-cycle values matter.
- resp_ready asserted by a non-owner, or while no response is valid: ignored.
- Arithmetic: no processing in this block; widths pass through unchanged.

Test Plan:
- Reset: rst_n low mid-EXEC with port 0 active -> all outputs 0, alu_op=010 immediately. After release, no resp0_valid appears and the next grant goes to port 0.
- Single ADD: port 0, data1=5, data2=7, aluop=010, resp0_ready=1 -> req0_ready at T, resp0_valid only at T+2, result=12, zero=0, branch=0.
- Round-robin: both ports continuously valid -> grants in order 0,1,0,1 over 4 transactions, accepts spaced 3 cycles apart.
- Back-pressure: port 1 SUB 9-9, resp1_ready held low 4 cycles -> resp1_valid held with result=0, zero=1. req0_ready stays 0 throughout, even with req0_valid high.
- Branch sanitising: BEQ data1=data2=3 -> branch=1, result=0, zero=0. A following AND 6&3 -> result=2, branch=0. A following BNE 4,4 -> branch=0.
- Undefined op 100 -> accepted, response result=0, zero=0, branch=0, latency 2.
